// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of the shared data memory.
// Supports lockable multi-beat ownership, rejects misaligned accesses, and returns registered, width-extended read responses.

module dmem_arb_rsp #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_beat,
    input  logic          i_err,
    input  logic          i_we,
    input  logic          i_uns,
    input  logic [1:0]    i_width,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_rvalid,
    output logic          o_err,
    output logic [DW-1:0] o_rdata
);
    logic          r_rvalid;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] w_ext;

    // Memory already zero-extends, so only the sign fill has to be added here.
    always_comb begin
        w_ext = i_mem_rdata;
        case (i_width)
            2'd0:    w_ext = {{(DW-8){~i_uns & i_mem_rdata[7]}}, i_mem_rdata[7:0]};
            2'd1:    w_ext = {{(DW-16){~i_uns & i_mem_rdata[15]}}, i_mem_rdata[15:0]};
            default: w_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= i_beat;
            r_err    <= i_beat & i_err;
            if (i_beat)
                r_rdata <= (i_we | i_err) ? '0 : w_ext;
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_err    = r_err;
    assign o_rdata  = r_rdata;
endmodule

module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          uns0,
    input  logic          uns1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [1:0]    width0,
    input  logic [1:0]    width1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_width,
    input  logic [DW-1:0] mem_rdata
);
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {OWN_NONE, OWN_0, OWN_1} owner_t;

    owner_t r_owner;
    logic   r_prio;

    logic [NUM_REQ-1:0]         w_req;
    logic [NUM_REQ-1:0]         w_we;
    logic [NUM_REQ-1:0]         w_lock;
    logic [NUM_REQ-1:0]         w_uns;
    logic [NUM_REQ-1:0][AW-1:0] w_addr;
    logic [NUM_REQ-1:0][DW-1:0] w_wdata;
    logic [NUM_REQ-1:0][1:0]    w_width;
    logic [NUM_REQ-1:0]         w_gnt;
    logic [NUM_REQ-1:0]         w_rvalid;
    logic [NUM_REQ-1:0]         w_err;
    logic [NUM_REQ-1:0][DW-1:0] w_rdata;
    logic                       w_sel;
    logic                       w_any;
    logic                       w_mis;

    assign w_req   = {req1, req0};
    assign w_we    = {we1, we0};
    assign w_lock  = {lock1, lock0};
    assign w_uns   = {uns1, uns0};
    assign w_addr  = {addr1, addr0};
    assign w_wdata = {wdata1, wdata0};
    assign w_width = {width1, width0};

    // An owner blocks the other side even while the owner itself is idle.
    always_comb begin
        w_gnt = '0;
        if (reset) begin
            case (r_owner)
                OWN_0:   w_gnt[0] = w_req[0];
                OWN_1:   w_gnt[1] = w_req[1];
                default: begin
                    if (&w_req)
                        w_gnt[r_prio] = 1'b1;
                    else
                        w_gnt = w_req;
                end
            endcase
        end
    end

    assign w_sel = w_gnt[1];
    assign w_any = |w_gnt;

    always_comb begin
        case (w_width[w_sel])
            2'd0:    w_mis = 1'b0;
            2'd1:    w_mis = w_addr[w_sel][0];
            default: w_mis = |w_addr[w_sel][1:0];
        endcase
    end

    assign mem_addr  = w_addr[w_sel];
    assign mem_wdata = w_wdata[w_sel];
    assign mem_width = w_width[w_sel];
    assign mem_wr    = w_any & w_we[w_sel] & ~w_mis;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner <= OWN_NONE;
            r_prio  <= 1'b0;
        end else if (w_any) begin
            r_prio  <= ~w_sel;
            if (w_lock[w_sel])
                r_owner <= w_sel ? OWN_1 : OWN_0;
            else
                r_owner <= OWN_NONE;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        dmem_arb_rsp #(.DW(DW)) u_rsp (
            .clk        (clk),
            .reset      (reset),
            .i_beat     (w_gnt[g]),
            .i_err      (w_mis),
            .i_we       (w_we[g]),
            .i_uns      (w_uns[g]),
            .i_width    (w_width[g]),
            .i_mem_rdata(mem_rdata),
            .o_rvalid   (w_rvalid[g]),
            .o_err      (w_err[g]),
            .o_rdata    (w_rdata[g])
        );
    end

    assign gnt0    = w_gnt[0];
    assign gnt1    = w_gnt[1];
    assign rvalid0 = w_rvalid[0];
    assign rvalid1 = w_rvalid[1];
    assign err0    = w_err[0];
    assign err1    = w_err[1];
    assign rdata0  = w_rdata[0];
    assign rdata1  = w_rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a byte-level reference model.

module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1, uns0, uns1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  width0, width1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_wr;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_width;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .uns0(uns0), .uns1(uns1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .width0(width0), .width1(width1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_width(mem_width), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT: 256 bytes, little-endian, zero-extended reads.
    logic [7:0] env_mem [0:255];
    logic [7:0] ea;
    assign ea = mem_addr[7:0];
    always_comb begin
        mem_rdata = {24'd0, env_mem[ea]};
        if (mem_width == 2'd1)
            mem_rdata = {16'd0, env_mem[ea + 8'd1], env_mem[ea]};
        else if (mem_width[1])
            mem_rdata = {env_mem[ea + 8'd3], env_mem[ea + 8'd2], env_mem[ea + 8'd1], env_mem[ea]};
    end
    always @(posedge clk) begin
        if (mem_wr) begin
            env_mem[ea] <= mem_wdata[7:0];
            if (mem_width != 2'd0) env_mem[ea + 8'd1] <= mem_wdata[15:8];
            if (mem_width[1]) begin
                env_mem[ea + 8'd2] <= mem_wdata[23:16];
                env_mem[ea + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    // Reference model: owner 0=none,1=req0,2=req1; its own byte memory.
    logic [7:0] ref_mem [0:255];
    int          m_owner, m_prio, m_who;
    logic        m_mis;
    logic        e_gnt0, e_gnt1, e_mwr, e_rv0, e_rv1, e_err0, e_err1;
    logic [31:0] e_rd0, e_rd1;

    function automatic logic mis_of(input logic [31:0] a, input logic [1:0] w);
        if (w == 2'd0) return 1'b0;
        if (w == 2'd1) return a[0];
        return a[1:0] != 2'd0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [7:0] a, input logic [1:0] w, input logic u);
        logic [31:0] v;
        if (w == 2'd0) begin
            v = 32'(ref_mem[a]);
            if (!u && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (w == 2'd1) begin
            v = 32'(ref_mem[a]) + 32'(ref_mem[a + 8'd1]) * 256;
            if (!u && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = 32'(ref_mem[a]) + 32'(ref_mem[a + 8'd1]) * 256
              + 32'(ref_mem[a + 8'd2]) * 65536 + 32'(ref_mem[a + 8'd3]) * 16777216;
        end
        return v;
    endfunction

    task automatic ref_write(input logic [7:0] a, input logic [1:0] w, input logic [31:0] d);
        int nb;
        nb = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        for (int k = 0; k < nb; k++)
            ref_mem[a + 8'(k)] = 8'((d >> (8 * k)) & 32'hFF);
    endtask

    task automatic model_eval();
        e_gnt0 = 1'b0;
        e_gnt1 = 1'b0;
        if (reset) begin
            if (m_owner == 1)      e_gnt0 = req0;
            else if (m_owner == 2) e_gnt1 = req1;
            else if (req0 && req1) begin
                e_gnt0 = (m_prio == 0);
                e_gnt1 = (m_prio == 1);
            end else begin
                e_gnt0 = req0;
                e_gnt1 = req1;
            end
        end
        m_who = e_gnt0 ? 0 : (e_gnt1 ? 1 : -1);
        m_mis = 1'b0;
        e_mwr = 1'b0;
        if (m_who == 0) begin
            m_mis = mis_of(addr0, width0);
            e_mwr = we0 && !m_mis;
        end else if (m_who == 1) begin
            m_mis = mis_of(addr1, width1);
            e_mwr = we1 && !m_mis;
        end
    endtask

    task automatic model_commit();
        if (!reset) begin
            m_owner = 0; m_prio = 0;
            e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0; e_rd0 = 0; e_rd1 = 0;
        end else begin
            e_rv0  = (m_who == 0);
            e_rv1  = (m_who == 1);
            e_err0 = e_rv0 && m_mis;
            e_err1 = e_rv1 && m_mis;
            if (m_who == 0) begin
                e_rd0 = (we0 || m_mis) ? 32'd0 : ref_read(addr0[7:0], width0, uns0);
                if (we0 && !m_mis) ref_write(addr0[7:0], width0, wdata0);
                m_prio  = 1;
                m_owner = lock0 ? 1 : 0;
            end else if (m_who == 1) begin
                e_rd1 = (we1 || m_mis) ? 32'd0 : ref_read(addr1[7:0], width1, uns1);
                if (we1 && !m_mis) ref_write(addr1[7:0], width1, wdata1);
                m_prio  = 0;
                m_owner = lock1 ? 2 : 0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, w, l, u, input logic [31:0] a, d, input logic [1:0] wd);
        req0 = r; we0 = w; lock0 = l; uns0 = u; addr0 = a; wdata0 = d; width0 = wd;
    endtask

    task automatic set1(input logic r, w, l, u, input logic [31:0] a, d, input logic [1:0] wd);
        req1 = r; we1 = w; lock1 = l; uns1 = u; addr1 = a; wdata1 = d; width1 = wd;
    endtask

    task automatic idle();
        set0(0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
        set1(0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set0(1, 1, 1, 0, 32'h10, 32'h1, 2'd2);
        set1(1, 1, 1, 0, 32'h14, 32'h2, 2'd2);
        settle();
        n_checks++;
        if ({gnt0, gnt1, mem_wr} !== 3'b000) begin
            n_fail++; $display("FAIL reset_gnt: got gnt0/gnt1/mem_wr=%b expected 000", {gnt0, gnt1, mem_wr});
        end
        advance();
        settle();
        n_checks++;
        if ({rvalid0, rvalid1, err0, err1} !== 4'b0000 || rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
            n_fail++; $display("FAIL reset_rsp: got rv=%b%b err=%b%b rd0=%h rd1=%h expected all zero",
                               rvalid0, rvalid1, err0, err1, rdata0, rdata1);
        end
        advance();
        reset = 1'b1;
        idle();
    endtask

    task automatic test_word_rw();
        set1(1, 1, 0, 0, 32'h10, 32'hDEADBEEF, 2'd2);
        settle();
        n_checks++;
        if (gnt1 !== 1'b1 || mem_wr !== 1'b1) begin
            n_fail++; $display("FAIL word_write: got gnt1=%b mem_wr=%b expected 1 1", gnt1, mem_wr);
        end
        advance();
        idle();
        set0(1, 0, 0, 0, 32'h10, 32'h0, 2'd2);
        settle();
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL word_read_gnt: got gnt0=%b expected 1", gnt0);
        end
        advance();
        idle();
        settle();
        n_checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || err0 !== 1'b0) begin
            n_fail++; $display("FAIL word_read_rsp: got rv=%b rd=%h err=%b expected 1 deadbeef 0", rvalid0, rdata0, err0);
        end
        advance();
    endtask

    task automatic test_alternate();
        int c0, c1;
        c0 = 0; c1 = 0;
        reset = 1'b0;
        settle();
        advance();
        reset = 1'b1;
        set0(1, 0, 0, 0, 32'h10, 32'h0, 2'd2);
        set1(1, 0, 0, 0, 32'h10, 32'h0, 2'd2);
        for (int i = 0; i < 8; i++) begin
            settle();
            c0 += int'(rvalid0);
            c1 += int'(rvalid1);
            n_checks++;
            if (gnt0 !== ((i % 2) == 0) || gnt1 !== ((i % 2) == 1)) begin
                n_fail++; $display("FAIL alternate_gnt[%0d]: got gnt0=%b gnt1=%b expected %b %b",
                                   i, gnt0, gnt1, (i % 2) == 0, (i % 2) == 1);
            end
            advance();
        end
        idle();
        settle();
        c0 += int'(rvalid0);
        c1 += int'(rvalid1);
        advance();
        n_checks++;
        if (c0 != 4 || c1 != 4) begin
            n_fail++; $display("FAIL alternate_rvalid: got %0d/%0d pulses expected 4/4", c0, c1);
        end
    endtask

    task automatic test_sign_ext();
        set1(1, 1, 0, 0, 32'h21, 32'hABCDEF80, 2'd0);
        settle();
        advance();
        idle();
        set0(1, 0, 0, 0, 32'h21, 32'h0, 2'd0);
        settle();
        advance();
        set0(1, 0, 0, 1, 32'h21, 32'h0, 2'd0);
        settle();
        n_checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL byte_signed: got rv=%b rd=%h expected 1 ffffff80", rvalid0, rdata0);
        end
        advance();
        idle();
        settle();
        n_checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'h00000080) begin
            n_fail++; $display("FAIL byte_unsigned: got rv=%b rd=%h expected 1 00000080", rvalid0, rdata0);
        end
        advance();
    endtask

    task automatic test_misaligned();
        set1(1, 1, 0, 0, 32'h23, 32'h1234, 2'd1);
        settle();
        n_checks++;
        if (gnt1 !== 1'b1 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL misalign_wr: got gnt1=%b mem_wr=%b expected 1 0", gnt1, mem_wr);
        end
        advance();
        set1(1, 0, 0, 1, 32'h20, 32'h0, 2'd2);
        settle();
        n_checks++;
        if (rvalid1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'd0) begin
            n_fail++; $display("FAIL misalign_rsp: got rv=%b err=%b rd=%h expected 1 1 0", rvalid1, err1, rdata1);
        end
        advance();
        idle();
        settle();
        n_checks++;
        if (rvalid1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== 32'h00008000) begin
            n_fail++; $display("FAIL misalign_unchanged: got rv=%b err=%b rd=%h expected 1 0 00008000", rvalid1, err1, rdata1);
        end
        advance();
    endtask

    task automatic test_lock();
        set0(1, 0, 0, 0, 32'h40, 32'h0, 2'd2);
        settle();
        advance();
        set1(1, 0, 1, 0, 32'h44, 32'h0, 2'd2);
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++;
            if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
                n_fail++; $display("FAIL lock_beat[%0d]: got gnt0=%b gnt1=%b expected 0 1", i, gnt0, gnt1);
            end
            advance();
        end
        req1 = 1'b0;
        settle();
        n_checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL lock_idle_owner: got gnt0=%b gnt1=%b expected 0 0", gnt0, gnt1);
        end
        advance();
        set1(1, 0, 0, 0, 32'h44, 32'h0, 2'd2);
        settle();
        n_checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            n_fail++; $display("FAIL lock_release: got gnt0=%b gnt1=%b expected 0 1", gnt0, gnt1);
        end
        advance();
        settle();
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL lock_after: got gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
        end
        advance();
        idle();
    endtask

    task automatic test_reset_mid_lock();
        set1(1, 0, 1, 0, 32'h10, 32'h0, 2'd2);
        settle();
        advance();
        reset = 1'b0;
        settle();
        n_checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL midlock_gnt: got gnt0=%b gnt1=%b mem_wr=%b expected 000", gnt0, gnt1, mem_wr);
        end
        advance();
        reset = 1'b1;
        idle();
        set0(1, 0, 0, 0, 32'h10, 32'h0, 2'd2);
        settle();
        n_checks++;
        if (rvalid1 !== 1'b0 || gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL midlock_after: got rvalid1=%b gnt0=%b expected 0 1", rvalid1, gnt0);
        end
        advance();
        idle();
        settle();
        n_checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL midlock_read: got rv=%b rd=%h expected 1 deadbeef", rvalid0, rdata0);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            set1(1, 1, 0, 0, 32'h30 + 32'(4 * i), d, 2'd2);
            settle();
            advance();
            set1(0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
            set0(1, 0, 0, 0, 32'h30 + 32'(4 * i), 32'h0, 2'd2);
            settle();
            advance();
            idle();
            settle();
            n_checks++;
            if (rvalid0 !== 1'b1 || rdata0 !== d) begin
                n_fail++; $display("FAIL back_to_back[%0d]: got rv=%b rd=%h expected 1 %h", i, rvalid0, rdata0, d);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) != 0);
            set0($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
                 32'($urandom_range(0, 63)), $urandom, 2'($urandom));
            set1($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
                 32'($urandom_range(0, 63)), $urandom, 2'($urandom));
            settle();
            n_checks++;
            if (gnt0 !== e_gnt0 || gnt1 !== e_gnt1 || mem_wr !== e_mwr) begin
                n_fail++; $display("FAIL rand_gnt[%0d]: got gnt=%b%b wr=%b expected %b%b %b",
                                   i, gnt0, gnt1, mem_wr, e_gnt0, e_gnt1, e_mwr);
            end
            n_checks++;
            if (rvalid0 !== e_rv0 || err0 !== e_err0 || rdata0 !== e_rd0) begin
                n_fail++; $display("FAIL rand_rsp0[%0d]: got rv=%b err=%b rd=%h expected %b %b %h",
                                   i, rvalid0, err0, rdata0, e_rv0, e_err0, e_rd0);
            end
            n_checks++;
            if (rvalid1 !== e_rv1 || err1 !== e_err1 || rdata1 !== e_rd1) begin
                n_fail++; $display("FAIL rand_rsp1[%0d]: got rv=%b err=%b rd=%h expected %b %b %h",
                                   i, rvalid1, err1, rdata1, e_rv1, e_err1, e_rd1);
            end
            advance();
        end
        reset = 1'b1;
        idle();
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            env_mem[k] = 8'h00;
            ref_mem[k] = 8'h00;
        end
        m_owner = 0; m_prio = 0; m_who = -1; m_mis = 0;
        e_gnt0 = 0; e_gnt1 = 0; e_mwr = 0;
        e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0; e_rd0 = 0; e_rd1 = 0;
        reset = 1'b0;
        idle();
        repeat (2) begin
            settle();
            advance();
        end
        test_reset();
        test_word_rw();
        test_alternate();
        test_sign_ext();
        test_misaligned();
        test_lock();
        test_reset_mid_lock();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
